cic_iq_sequencer: RTL
=====================

// Module: cic_iq_sequencer
// PURPOSE
//  Controller between the I/Q sample FIFO and the 2-channel Avalon-ST decimating CIC.
//  Pops 24-bit {I,Q} words and feeds them to the CIC as ordered 2-beat packets
//  (I=ch0 with SOP, Q=ch1 with EOP) under full in_ready backpressure.
//  Re-pairs CIC outputs into one {I,Q} word, counts traffic and flags sticky errors.
//  Sits in the clk_dsp domain, after the FIFO read port and around the CIC core.
// PARAMETERS
//  IN_W   12  per-channel CIC input width; fifo_q is 2*IN_W, {I,Q} with I in the MSBs
//  OUT_W  25  per-channel CIC output width; data_out_iq is 2*OUT_W
//  CNT_W  16  width of the pair counters
// PORTS
//  clk_dsp         in   1        DSP clock; all logic on its rising edge
//  rst_dsp         in   1        asynchronous, active-high reset
//  enable          in   1        start/stop streaming
//  clr_err         in   1        one-cycle pulse that clears the sticky errors
//  fifo_q          in   2*IN_W   FIFO read data; valid 1 cycle after fifo_rdreq
//  fifo_rdempty    in   1        FIFO empty
//  fifo_rdreq      out  1        FIFO pop; one-cycle pulse
//  cic_in_data     out  IN_W     CIC sink data
//  cic_in_valid    out  1        CIC sink valid
//  cic_in_sop      out  1        CIC sink start of packet
//  cic_in_eop      out  1        CIC sink end of packet
//  cic_in_ready    in   1        CIC sink ready; ready latency 0
//  cic_out_data    in   OUT_W    CIC source data
//  cic_out_valid   in   1        CIC source valid
//  cic_out_channel in   1        CIC source channel; 0=I, 1=Q
//  cic_out_ready   out  1        CIC source ready
//  data_out_iq     out  2*OUT_W  paired output {I,Q}
//  data_out_valid  out  1        one-cycle strobe for data_out_iq
//  pairs_in        out  CNT_W    pairs accepted by the CIC; wraps
//  pairs_out       out  CNT_W    pairs emitted on data_out_iq; wraps
//  err_underrun    out  1        sticky: FIFO ran empty while streaming
//  err_seq         out  1        sticky: CIC output channel order broken
// BEHAVIOUR
//  Reset: every output and register is 0, except cic_out_ready=1 one cycle after reset release.
//  Input FSM states: IDLE, FETCH, LOAD, SEND_I, SEND_Q.
//  - IDLE -> FETCH when enable & ~fifo_rdempty.
//  - FETCH: fifo_rdreq=1 for exactly one cycle, then -> LOAD.
//  - LOAD: hold <= fifo_q, then -> SEND_I.
//  - SEND_I: valid=1, sop=1, eop=0, data=hold[2*IN_W-1:IN_W].
//    Stays until valid&ready, then -> SEND_Q.
//  - SEND_Q: valid=1, sop=0, eop=1, data=hold[IN_W-1:0].
//    On handshake: pairs_in+1; -> FETCH if enable & ~fifo_rdempty, else -> IDLE.
//  - Minimum 4 cycles per pair.
//  - cic_in_* is held stable while valid & ~ready. valid is never dropped without a handshake.
//  - fifo_rdreq is never asserted while fifo_rdempty=1.
//  - enable falling mid-pair: the current pair completes (I and Q both sent), then -> IDLE.
//    A pair is never split.
//  - err_underrun is set when SEND_Q completes with enable=1 and fifo_rdempty=1.
//    Applies only after the first pair has been sent since reset.
//  Output collector:
//  - On valid & ch0: ireg <= cic_out_data.
//  - On valid & ch1 with ireg pending: data_out_iq={ireg,cic_out_data}, data_out_valid=1 for
//    one cycle, pairs_out+1, pending cleared. data_out_iq holds until the next pair.
//  - ch0 while pending: set err_seq; the new I replaces the old one.
//  - ch1 with nothing pending: set err_seq; the sample is dropped, no strobe.
//  - Collector latency: data_out_valid is registered 1 cycle after the ch1 beat.
//  Errors: sticky until clr_err. If clr_err and a new error event fall in the same cycle,
//    the set wins.
//  Counters wrap modulo 2^CNT_W silently.
//  Reset mid-operation: everything returns to reset values; the held pair and the pending I are lost.
// STRUCTURE
//  - Package cic_seq_pkg: input FSM state encoding; CH_I=0, CH_Q=1; IN_W/OUT_W defaults.
//  - Sub-module cic_iq_collector: output pairing, pairs_out counter, err_seq.
//  - Top level holds the input FSM, hold register, pairs_in counter and err_underrun.
// TESTING
//  1. FIFO holds {12'hABC,12'h123}, enable=1, ready=1 ->
//     rdreq pulse; then beat 0xABC with sop, then beat 0x123 with eop; pairs_in=1.
//  2. ready=0 for 5 cycles during SEND_I -> data 0xABC, sop and valid stay stable for 5 cycles;
//     exactly one I beat after ready=1.
//  3. enable dropped in the SEND_I cycle -> Q beat still sent, FSM goes IDLE, no further rdreq.
//  4. CIC out ch0=25'h1, ch1=25'h2 -> data_out_iq={25'h1,25'h2}, one-cycle strobe; pairs_out=1.
//  5. CIC out ch1 with nothing pending, then ch0, ch0 -> err_seq=1, no strobe;
//     clr_err pulse -> err_seq=0.
//  6. One word in the FIFO, enable held high -> pair sent, then err_underrun=1;
//     pairs_in counts 16'hFFFF -> 0 on wrap.

Source files
------------

// File: rtl/cic_seq_pkg.sv
// Shared types and constants for the I/Q sequencer around the 2-channel decimating CIC.
package cic_seq_pkg;

  localparam int IN_W_DEF  = 12;
  localparam int OUT_W_DEF = 25;
  localparam int CNT_W_DEF = 16;

  localparam logic CH_I = 1'b0;
  localparam logic CH_Q = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_SEND_I,
    ST_SEND_Q
  } in_state_t;

endpackage

// File: rtl/cic_iq_sequencer_if.sv
// FIFO read port plus CIC sink/source streaming signals, seen from the sequencer (master).
interface cic_iq_sequencer_if
  import cic_seq_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF
);

  logic [2*IN_W-1:0] fifo_q;
  logic              fifo_rdempty;
  logic              fifo_rdreq;

  logic [IN_W-1:0]   cic_in_data;
  logic              cic_in_valid;
  logic              cic_in_sop;
  logic              cic_in_eop;
  logic              cic_in_ready;

  logic [OUT_W-1:0]  cic_out_data;
  logic              cic_out_valid;
  logic              cic_out_channel;
  logic              cic_out_ready;

  modport master (
    input  fifo_q, fifo_rdempty,
    output fifo_rdreq,
    output cic_in_data, cic_in_valid, cic_in_sop, cic_in_eop,
    input  cic_in_ready,
    input  cic_out_data, cic_out_valid, cic_out_channel,
    output cic_out_ready
  );

  modport slave (
    output fifo_q, fifo_rdempty,
    input  fifo_rdreq,
    input  cic_in_data, cic_in_valid, cic_in_sop, cic_in_eop,
    output cic_in_ready,
    output cic_out_data, cic_out_valid, cic_out_channel,
    input  cic_out_ready
  );

endinterface

// File: rtl/cic_iq_collector.sv
// Re-pairs CIC source beats (ch0=I, ch1=Q) into one {I,Q} word; counts pairs and flags order errors.
module cic_iq_collector
  import cic_seq_pkg::*;
#(
  parameter int OUT_W = OUT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               clk_dsp,
  input  logic               rst_dsp,
  input  logic               clr_err,
  input  logic [OUT_W-1:0]   data,
  input  logic               valid,
  input  logic               channel,
  output logic               ready,
  output logic [2*OUT_W-1:0] data_out_iq,
  output logic               data_out_valid,
  output logic [CNT_W-1:0]   pairs_out,
  output logic               err_seq
);

  logic [OUT_W-1:0] ireg;
  logic             pending;
  logic             accept;
  logic             seq_event;

  assign accept    = valid & ready;
  assign seq_event = accept & ((channel == CH_I) ? pending : ~pending);

  // Ready rises only once reset has been released for a full cycle.
  always_ff @(posedge clk_dsp or posedge rst_dsp) begin
    if (rst_dsp) ready <= 1'b0;
    else         ready <= 1'b1;
  end

  always_ff @(posedge clk_dsp or posedge rst_dsp) begin
    if (rst_dsp) begin
      ireg           <= '0;
      pending        <= 1'b0;
      data_out_iq    <= '0;
      data_out_valid <= 1'b0;
      pairs_out      <= '0;
    end else begin
      data_out_valid <= 1'b0;
      if (accept) begin
        if (channel == CH_I) begin
          ireg    <= data;
          pending <= 1'b1;
        end else if (pending) begin
          data_out_iq    <= {ireg, data};
          data_out_valid <= 1'b1;
          pairs_out      <= pairs_out + CNT_W'(1);
          pending        <= 1'b0;
        end
      end
    end
  end

  // A new error in the same cycle as clr_err must survive the clear.
  always_ff @(posedge clk_dsp or posedge rst_dsp) begin
    if (rst_dsp)        err_seq <= 1'b0;
    else if (seq_event) err_seq <= 1'b1;
    else if (clr_err)   err_seq <= 1'b0;
  end

endmodule

// File: rtl/cic_iq_sequencer.sv
// Pops {I,Q} words from the sample FIFO and feeds the CIC as SOP/EOP 2-beat packets.
module cic_iq_sequencer
  import cic_seq_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               clk_dsp,
  input  logic               rst_dsp,
  input  logic               enable,
  input  logic               clr_err,
  cic_iq_sequencer_if.master bus,
  output logic [2*OUT_W-1:0] data_out_iq,
  output logic               data_out_valid,
  output logic [CNT_W-1:0]   pairs_in,
  output logic [CNT_W-1:0]   pairs_out,
  output logic               err_underrun,
  output logic               err_seq
);

  in_state_t         state, state_nxt;
  logic [2*IN_W-1:0] hold;
  logic              have_work;
  logic              pair_done;
  logic              rdreq;
  logic [IN_W-1:0]   in_data;
  logic              in_valid, in_sop, in_eop;
  logic              out_ready;

  assign have_work = enable & ~bus.fifo_rdempty;
  assign pair_done = (state == ST_SEND_Q) & bus.cic_in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_dsp or posedge rst_dsp) begin
    if (rst_dsp) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // NOTE: every output gets a default first, so no path through the case can infer a latch.
  always_comb begin
    state_nxt = state;
    rdreq     = 1'b0;
    in_valid  = 1'b0;
    in_sop    = 1'b0;
    in_eop    = 1'b0;
    in_data   = '0;
    case (state)
      ST_IDLE:   if (have_work) state_nxt = ST_FETCH;
      ST_FETCH: begin
        // Guard keeps the pop legal even if the FIFO emptied behind our back.
        if (!bus.fifo_rdempty) begin
          rdreq     = 1'b1;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD:   state_nxt = ST_SEND_I;
      ST_SEND_I: begin
        in_valid = 1'b1;
        in_sop   = 1'b1;
        in_data  = hold[2*IN_W-1:IN_W];
        if (bus.cic_in_ready) state_nxt = ST_SEND_Q;
      end
      ST_SEND_Q: begin
        in_valid = 1'b1;
        in_eop   = 1'b1;
        in_data  = hold[IN_W-1:0];
        if (bus.cic_in_ready) state_nxt = have_work ? ST_FETCH : ST_IDLE;
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign bus.fifo_rdreq   = rdreq;
  assign bus.cic_in_valid = in_valid;
  assign bus.cic_in_sop   = in_sop;
  assign bus.cic_in_eop   = in_eop;
  assign bus.cic_in_data  = in_data;
  assign bus.cic_out_ready = out_ready;

  // NOTE: the hold register is reset too, so a reset mid-pair cannot replay stale samples.
  always_ff @(posedge clk_dsp or posedge rst_dsp) begin
    if (rst_dsp)                hold <= '0;
    else if (state == ST_LOAD)  hold <= bus.fifo_q;
  end

  always_ff @(posedge clk_dsp or posedge rst_dsp) begin
    if (rst_dsp)        pairs_in <= '0;
    else if (pair_done) pairs_in <= pairs_in + CNT_W'(1);
  end

  always_ff @(posedge clk_dsp or posedge rst_dsp) begin
    if (rst_dsp)                                       err_underrun <= 1'b0;
    else if (pair_done && enable && bus.fifo_rdempty)  err_underrun <= 1'b1;
    else if (clr_err)                                  err_underrun <= 1'b0;
  end

  cic_iq_collector #(
    .OUT_W (OUT_W),
    .CNT_W (CNT_W)
  ) u_collector (
    .clk_dsp        (clk_dsp),
    .rst_dsp        (rst_dsp),
    .clr_err        (clr_err),
    .data           (bus.cic_out_data),
    .valid          (bus.cic_out_valid),
    .channel        (bus.cic_out_channel),
    .ready          (out_ready),
    .data_out_iq    (data_out_iq),
    .data_out_valid (data_out_valid),
    .pairs_out      (pairs_out),
    .err_seq        (err_seq)
  );

endmodule
